cb_douta_router: RTL and testbench

//  Parametrised successor to the CB port-A read-data mapper. Accepts a map command issued with each CB BRAM read,

---
 rtl/cb_map_pkg.sv | 29 ++
 rtl/cb_douta_router_chk.sv | 22 ++
 rtl/cb_lane_permute.sv | 46 ++++
 rtl/cb_douta_router.sv | 176 +++++++++++++++++
 tb/tb_cb_douta_router.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/cb_map_pkg.sv
// Shared codes and command type for the CB port-A read-data mapping path.
package cb_map_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_POS  = 2'b01,
    DIR_REV  = 2'b10,
    DIR_NEW  = 2'b11
  } dir_e;

  localparam int DEST_A = 0;
  localparam int DEST_B = 1;
  localparam int DEST_M = 2;

  localparam int CMD_DEST_W = 2;
  localparam int CMD_LNUM_W = 2;

  typedef struct packed {
    logic [CMD_DEST_W-1:0] dest;
    dir_e                  dir;
    logic [CMD_LNUM_W-1:0] lnum;
  } cmd_t;

  // Destination index width, never below one bit.
  function automatic int dest_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cb_douta_router_chk.sv
// Property checks for the router: FIFO overflow and unpresentable destinations.
module cb_douta_router_chk #(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_DEST   = 3,
  parameter int CW         = 3,
  parameter int DW         = 2
) (
  input logic          clk,
  input logic          i_rst_n,
  input logic          i_push,
  input logic          i_pop,
  input logic [CW-1:0] i_cnt,
  input logic [DW-1:0] i_push_dest
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!i_rst_n)
    !(i_push && !i_pop && (i_cnt == CW'(FIFO_DEPTH))));

  a_dest_range: assert property (@(posedge clk) disable iff (!i_rst_n)
    !(i_push && (int'(i_push_dest) >= NUM_DEST)));

endmodule

// File: rtl/cb_lane_permute.sv
// Combinational L-lane permutation of one CB read word: forward, reverse, or
// NEW-landmark bank-pair select into lanes 0/1.
module cb_lane_permute
  import cb_map_pkg::*;
#(
  parameter int L      = 4,
  parameter int RSA_DW = 16,
  parameter int LW     = 2
) (
  input  logic [L*RSA_DW-1:0] i_data,
  input  dir_e                i_dir,
  input  logic [LW-1:0]       i_lnum,
  output logic [L*RSA_DW-1:0] o_data
);

  int w_k;
  int w_g;
  int w_s;

  // Bank pair g and swap flag come from (lnum+1) mod L folded around L/2.
  always_comb begin
    o_data = '0;
    w_k    = (int'(i_lnum) + 1) % L;
    if (w_k < L / 2) begin
      w_g = w_k;
      w_s = 0;
    end else begin
      w_g = L - 1 - w_k;
      w_s = 1;
    end
    case (i_dir)
      DIR_POS: o_data = i_data;
      DIR_REV: begin
        for (int i = 0; i < L; i++) begin
          o_data[i*RSA_DW +: RSA_DW] = i_data[(L-1-i)*RSA_DW +: RSA_DW];
        end
      end
      DIR_NEW: begin
        o_data[0      +: RSA_DW] = i_data[(2*w_g+w_s)*RSA_DW +: RSA_DW];
        o_data[RSA_DW +: RSA_DW] = i_data[(2*w_g+1-w_s)*RSA_DW +: RSA_DW];
      end
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/cb_douta_router.sv
// Aligns map commands with CB_douta, lane-permutes the word and queues it in a
// credit-protected show-ahead FIFO toward NUM_DEST valid/ready consumers.
module cb_douta_router
  import cb_map_pkg::*;
#(
  parameter int L          = 4,
  parameter int RSA_DW     = 16,
  parameter int NUM_DEST   = 3,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int DW        = dest_w(NUM_DEST),
  localparam int LW        = $clog2(L),
  localparam int DATA_W    = L * RSA_DW
) (
  input  logic                clk,
  input  logic                sys_rst_n,
  input  logic                flush,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DW-1:0]       cmd_dest,
  input  logic [1:0]          cmd_dir,
  input  logic [LW-1:0]       cmd_lnum,
  input  logic [DATA_W-1:0]   CB_douta,
  output logic [NUM_DEST-1:0] out_valid,
  input  logic [NUM_DEST-1:0] out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [DW-1:0]       out_dest
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [RD_LAT-1:0] r_dl_v;
  logic [DW-1:0]     r_dl_dest [RD_LAT];
  dir_e              r_dl_dir  [RD_LAT];
  logic [LW-1:0]     r_dl_lnum [RD_LAT];

  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic [DW-1:0]     r_mem_dest [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_cnt, r_cred;
  logic              r_rdy;
  logic [NUM_DEST-1:0] r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic [DW-1:0]       r_out_dest;

  logic              w_acc, w_push, w_pop;
  logic [DATA_W-1:0] w_map_data, w_head_data, w_out_data_nxt;
  logic [DW-1:0]     w_head_dest, w_out_dest_nxt;
  logic [PW-1:0]     w_wr_nxt, w_rd_nxt;
  logic [CW-1:0]     w_cnt_nxt, w_cred_nxt;
  logic [NUM_DEST-1:0] w_out_valid_nxt;

  assign w_acc     = cmd_valid & r_rdy;
  assign w_push    = r_dl_v[RD_LAT-1] & ~flush;
  assign w_pop     = |(r_out_valid & out_ready);
  assign cmd_ready = r_rdy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_dest  = r_out_dest;

  cb_lane_permute #(.L(L), .RSA_DW(RSA_DW), .LW(LW)) u_permute (
    .i_data (CB_douta),
    .i_dir  (r_dl_dir[RD_LAT-1]),
    .i_lnum (r_dl_lnum[RD_LAT-1]),
    .o_data (w_map_data)
  );

  // Command delay line; flush kills in-flight valids so late read data is dropped.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int j = 0; j < RD_LAT; j++) begin
        r_dl_v[j]    <= 1'b0;
        r_dl_dest[j] <= '0;
        r_dl_dir[j]  <= DIR_IDLE;
        r_dl_lnum[j] <= '0;
      end
    end else begin
      r_dl_v[0]    <= w_acc & ~flush;
      r_dl_dest[0] <= cmd_dest;
      r_dl_dir[0]  <= dir_e'(cmd_dir);
      r_dl_lnum[0] <= cmd_lnum;
      for (int j = 1; j < RD_LAT; j++) begin
        r_dl_v[j]    <= r_dl_v[j-1] & ~flush;
        r_dl_dest[j] <= r_dl_dest[j-1];
        r_dl_dir[j]  <= r_dl_dir[j-1];
        r_dl_lnum[j] <= r_dl_lnum[j-1];
      end
    end
  end

  // Next FIFO/credit state and next head; a push into an otherwise-empty FIFO becomes the head.
  always_comb begin
    if (flush) begin
      w_wr_nxt   = '0;
      w_rd_nxt   = '0;
      w_cnt_nxt  = '0;
      w_cred_nxt = CW'(FIFO_DEPTH);
    end else begin
      w_wr_nxt   = r_wr_ptr + PW'(w_push);
      w_rd_nxt   = r_rd_ptr + PW'(w_pop);
      w_cnt_nxt  = r_cnt + CW'(w_push) - CW'(w_pop);
      w_cred_nxt = r_cred + CW'(w_pop) - CW'(w_acc);
    end
    if (w_push && (r_cnt == CW'(w_pop))) begin
      w_head_data = w_map_data;
      w_head_dest = r_dl_dest[RD_LAT-1];
    end else begin
      w_head_data = r_mem_data[w_rd_nxt];
      w_head_dest = r_mem_dest[w_rd_nxt];
    end
    w_out_valid_nxt = '0;
    for (int d = 0; d < NUM_DEST; d++) begin
      if ((w_cnt_nxt != '0) && (w_head_dest == DW'(d))) begin
        w_out_valid_nxt[d] = 1'b1;
      end else begin
        w_out_valid_nxt[d] = 1'b0;
      end
    end
    if (w_cnt_nxt != '0) begin
      w_out_data_nxt = w_head_data;
      w_out_dest_nxt = w_head_dest;
    end else begin
      w_out_data_nxt = '0;
      w_out_dest_nxt = '0;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        r_mem_data[e] <= '0;
        r_mem_dest[e] <= '0;
      end
    end else if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_map_data;
      r_mem_dest[r_wr_ptr] <= r_dl_dest[RD_LAT-1];
    end
  end

  // Pointers, credits and registered head outputs.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_cred      <= CW'(FIFO_DEPTH);
      r_rdy       <= 1'b0;
      r_out_valid <= '0;
      r_out_data  <= '0;
      r_out_dest  <= '0;
    end else begin
      r_wr_ptr    <= w_wr_nxt;
      r_rd_ptr    <= w_rd_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cred      <= w_cred_nxt;
      r_rdy       <= (w_cred_nxt != '0);
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_dest  <= w_out_dest_nxt;
    end
  end

  cb_douta_router_chk #(
    .FIFO_DEPTH(FIFO_DEPTH), .NUM_DEST(NUM_DEST), .CW(CW), .DW(DW)
  ) u_chk (
    .clk         (clk),
    .i_rst_n     (sys_rst_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_cnt       (r_cnt),
    .i_push_dest (r_dl_dest[RD_LAT-1])
  );

endmodule

// File: tb/tb_cb_douta_router.sv
// Directed bench for cb_douta_router at L=4, RSA_DW=16, RD_LAT=1, FIFO_DEPTH=4, NUM_DEST=3.
module tb_cb_douta_router;
  import cb_map_pkg::*;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        flush;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_dest;
  logic [1:0]  cmd_dir;
  logic [1:0]  cmd_lnum;
  logic [63:0] cb_douta;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [63:0] out_data;
  logic [1:0]  out_dest;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [63:0] D_IN  = 64'h0004_0003_0002_0001;
  localparam logic [63:0] D_REV = 64'h0001_0002_0003_0004;

  cb_douta_router dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .flush     (flush),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dest  (cmd_dest),
    .cmd_dir   (cmd_dir),
    .cmd_lnum  (cmd_lnum),
    .CB_douta  (cb_douta),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_dest  (out_dest)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int base, input int i);
    return {16'(i + 4), 16'(i + 3), 16'(i + 2), 16'(base + i)};
  endfunction

  // One command into an empty FIFO with out_ready=111: visible two cycles after issue, then popped.
  task automatic single(input string tag, input logic [1:0] dest, input logic [1:0] dir,
                        input logic [1:0] lnum, input logic [63:0] din,
                        input logic [63:0] exp_data, input logic [2:0] exp_v);
    cmd_valid = 1'b1; cmd_dest = dest; cmd_dir = dir; cmd_lnum = lnum;
    step();
    cmd_valid = 1'b0; cb_douta = din;
    step();
    check_eq({tag, "_valid"}, 64'(out_valid), 64'(exp_v));
    check_eq({tag, "_data"},  out_data, exp_data);
    check_eq({tag, "_dest"},  64'(out_dest), 64'(dest));
    step();
    check_eq({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  logic [1:0]  mix_dest [4];
  logic [2:0]  mix_onehot [4];
  int          acc;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mix_dest   = '{2'(DEST_A), 2'(DEST_B), 2'(DEST_M), 2'(DEST_A)};
    mix_onehot = '{3'b001, 3'b010, 3'b100, 3'b001};
    sys_rst_n = 1'b0; flush = 1'b0; cmd_valid = 1'b0;
    cmd_dest = 2'd0; cmd_dir = 2'd0; cmd_lnum = 2'd0;
    cb_douta = 64'd0; out_ready = 3'b111;

    // Reset state
    step(); step();
    check_eq("rst_ready", 64'(cmd_ready), 64'd0);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_data",  out_data, 64'd0);
    sys_rst_n = 1'b1;
    step();
    check_eq("rel_ready", 64'(cmd_ready), 64'd1);
    check_eq("rel_cred",  64'(dut.r_cred), 64'd4);

    // Forward, reverse, idle bubble
    single("pos", 2'(DEST_A), DIR_POS, 2'd0, D_IN, D_IN, 3'b001);
    single("rev", 2'(DEST_A), DIR_REV, 2'd0, D_IN, D_REV, 3'b001);
    single("idle", 2'(DEST_M), DIR_IDLE, 2'd0, D_IN, 64'd0, 3'b100);

    // NEW landmark sweep
    single("new3", 2'(DEST_B), DIR_NEW, 2'd3, D_IN, 64'h0000_0000_0002_0001, 3'b010);
    single("new0", 2'(DEST_B), DIR_NEW, 2'd0, D_IN, 64'h0000_0000_0004_0003, 3'b010);
    single("new1", 2'(DEST_B), DIR_NEW, 2'd1, D_IN, 64'h0000_0000_0003_0004, 3'b010);
    single("new2", 2'(DEST_B), DIR_NEW, 2'd2, D_IN, 64'h0000_0000_0001_0002, 3'b010);

    // Back-pressure: six back-to-back commands, only four credits
    out_ready = 3'b000; acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_dest = 2'(DEST_A); cmd_dir = DIR_POS;
      cb_douta = pat(16'hB0, i - 1);
      if (cmd_ready) acc++;
      step();
    end
    cmd_valid = 1'b0; cb_douta = pat(16'hB0, 5);
    step();
    check_eq("bp_accepted", 64'(acc), 64'd4);
    check_eq("bp_ready_low", 64'(cmd_ready), 64'd0);
    check_eq("bp_cnt", 64'(dut.r_cnt), 64'd4);
    out_ready = 3'b111;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("bp_valid%0d", k), 64'(out_valid), 64'(3'b001));
      check_eq($sformatf("bp_data%0d", k), out_data, pat(16'hB0, k));
      step();
    end
    check_eq("bp_empty", 64'(out_valid), 64'd0);
    check_eq("bp_ready_back", 64'(cmd_ready), 64'd1);
    check_eq("bp_cred", 64'(dut.r_cred), 64'd4);

    // Mixed destinations, fill to full then drain with a new push during pops
    out_ready = 3'b000;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_dest = mix_dest[i]; cmd_dir = DIR_POS;
      cb_douta = pat(16'hC0, i - 1);
      step();
    end
    cmd_valid = 1'b0; cb_douta = pat(16'hC0, 3);
    step();
    check_eq("mix_full_ready", 64'(cmd_ready), 64'd0);
    check_eq("mix_v0", 64'(out_valid), 64'(mix_onehot[0]));
    check_eq("mix_d0", out_data, pat(16'hC0, 0));
    out_ready = 3'b111;
    step();
    check_eq("mix_v1", 64'(out_valid), 64'(mix_onehot[1]));
    check_eq("mix_d1", out_data, pat(16'hC0, 1));
    check_eq("mix_ready1", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_dest = 2'(DEST_B); cmd_dir = DIR_REV;
    step();
    check_eq("mix_v2", 64'(out_valid), 64'(mix_onehot[2]));
    check_eq("mix_d2", out_data, pat(16'hC0, 2));
    cmd_valid = 1'b0; cb_douta = D_IN;
    step();
    check_eq("mix_v3", 64'(out_valid), 64'(mix_onehot[3]));
    check_eq("mix_d3", out_data, pat(16'hC0, 3));
    step();
    check_eq("mix_v4", 64'(out_valid), 64'(3'b010));
    check_eq("mix_d4", out_data, D_REV);
    step();
    check_eq("mix_empty", 64'(out_valid), 64'd0);
    check_eq("mix_cred", 64'(dut.r_cred), 64'd4);

    // Flush with three queued and one in flight
    out_ready = 3'b000;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_dest = 2'(DEST_A); cmd_dir = DIR_POS;
      cb_douta = pat(16'hD0, i - 1);
      step();
    end
    check_eq("fl_queued", 64'(dut.r_cnt), 64'd3);
    cmd_valid = 1'b0; cb_douta = pat(16'hD0, 3); flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("fl_valid", 64'(out_valid), 64'd0);
    check_eq("fl_ready", 64'(cmd_ready), 64'd1);
    check_eq("fl_cred", 64'(dut.r_cred), 64'd4);
    step();
    check_eq("fl_late_valid", 64'(out_valid), 64'd0);
    check_eq("fl_late_cnt", 64'(dut.r_cnt), 64'd0);

    // Asynchronous reset mid-traffic
    cmd_valid = 1'b1; cmd_dest = 2'(DEST_A); cmd_dir = DIR_POS;
    step();
    cmd_valid = 1'b0; cb_douta = D_IN;
    step();
    check_eq("ar_pre_valid", 64'(out_valid), 64'(3'b001));
    #2 sys_rst_n = 1'b0;
    #1;
    check_eq("ar_valid", 64'(out_valid), 64'd0);
    check_eq("ar_data", out_data, 64'd0);
    check_eq("ar_ready", 64'(cmd_ready), 64'd0);
    #2 sys_rst_n = 1'b1;
    step();
    check_eq("ar_rel_ready", 64'(cmd_ready), 64'd1);
    check_eq("ar_rel_valid", 64'(out_valid), 64'd0);
    out_ready = 3'b111;
    single("post_rst", 2'(DEST_M), DIR_REV, 2'd0, D_IN, D_REV, 3'b100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
